regfile_bypass_sb: RTL
======================

// Module: regfile_bypass_sb
// PURPOSE
//  Parametrised CPU register file for the pipelined datapath: NUM_RD combinational read ports, one write port (WB stage).
//  Same-cycle write-to-read bypass removes the WB->ID read/write hazard without a separate compare unit.
//  Pending-write scoreboard marks destinations of issued loads; per-port busy flags drive the ID-stage stall.
//  Sits in ID; written by MEM/WB, read by decode; busy feeds the hazard/stall controller.
// PARAMETERS
//  DATA_W    64  register width in bits
//  ADDR_W    5   register index width (2**ADDR_W registers)
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  31  index hard-wired to zero (XZR); set to 2**ADDR_W to disable
//  BYPASS_EN 1   1 = same-cycle write->read forwarding; 0 = reads return stored value only
// PORTS
//  clk        in   1              single clock, all state updates on rising edge
//  reset      in   1              synchronous, active-high; clears all registers and scoreboard
//  wr_en      in   1              WB write strobe
//  wr_addr    in   ADDR_W         WB destination index
//  wr_data    in   DATA_W         WB write data
//  rd_addr    in   NUM_RD*ADDR_W  read indices, port i at [i*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
//  rd_byp     out  NUM_RD         port i took wr_data via bypass this cycle
//  pend_set   in   1              load issued; mark pend_addr as pending write
//  pend_addr  in   ADDR_W         destination of issued load
//  busy       out  NUM_RD         port i reads a pending register not resolved this cycle
//  pend_any   out  1              at least one scoreboard bit set
// BEHAVIOUR
//  Reset: at the first edge with reset=1, all registers := 0, all pending bits := 0. rd_data shows 0 from next cycle.
//   busy=0 and pend_any=0 from next cycle. Reset dominates wr_en/pend_set in the same cycle.
//  Write: edge with wr_en=1 and wr_addr!=ZERO_REG stores wr_data. Writes to ZERO_REG are dropped.
//  Read: combinational, 0 cycles latency. Per port i:
//   - rd_addr==ZERO_REG: rd_data=0, rd_byp=0, busy=0.
//   - else if BYPASS_EN && wr_en && wr_addr==rd_addr: rd_data=wr_data, rd_byp=1.
//   - else: rd_data=stored value, rd_byp=0.
//   - All ports are evaluated independently. Two ports may read the same index; both bypass.
//  Scoreboard: 2**ADDR_W bits, pend[r].
//   - set: edge with pend_set=1 and pend_addr!=ZERO_REG sets pend[pend_addr].
//   - clear: edge with wr_en=1 clears pend[wr_addr].
//   - set and clear to the same index in one cycle: set wins (a new load is outstanding).
//   - set and clear to different indices: both apply.
//   - set on an already-pending index: no change (no counting).
//   - busy[i] = pend[rd_addr_i] & ~(BYPASS_EN & wr_en & wr_addr==rd_addr_i) & (rd_addr_i!=ZERO_REG).
//   - pend_any = OR of pend[].
//  No X propagation: outputs are defined for all inputs once the first reset edge has passed.
// STRUCTURE
//  Package regfile_pkg holds:
//   - localparams DATA_W_DEF=64, ADDR_W_DEF=5, XZR=31.
//   - typedef logic [ADDR_W_DEF-1:0] reg_idx_t and typedef logic [DATA_W_DEF-1:0] reg_word_t.
//  Sub-module pending_scoreboard(clk, reset, set_en, set_idx, clr_en, clr_idx, pend_vec) holds the bit vector and set/clear priority.
//  Top level holds the storage array, read/bypass muxes per port (generate loop), and busy/pend_any logic.
// TESTING
//  1 reset=1 one cycle after random writes -> all rd_data=0, busy=0, pend_any=0 next cycle.
//  2 wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF, rd_addr0=5 in same cycle -> rd_data0=DEAD_BEEF, rd_byp0=1;
//    next cycle, wr_en=0 -> rd_data0=DEAD_BEEF, rd_byp0=0.
//  3 Write wr_addr=31, wr_data=64'h1234 -> reading index 31 gives 0 on all ports.
//    pend_set with pend_addr=31 -> pend_any stays 0.
//  4 pend_set, pend_addr=7 -> next cycle rd_addr1=7 gives busy1=1.
//    Then wr_en, wr_addr=7, wr_data=9 -> busy1=0 and rd_data1=9 in that cycle; next cycle pend_any=0.
//  5 Same cycle: pend_set with pend_addr=3, and wr_en with wr_addr=3 -> pend[3]=1 after the edge, so busy=1 on a read of 3 next cycle.
//  6 BYPASS_EN=0, NUM_RD=3: write addr 4 with wr_data=0xAA while reading 4 -> old value, rd_byp=0, busy not masked; next cycle reads 0xAA.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and index/word types for the register file slice.
package regfile_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int XZR        = 31;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_word_t;
endpackage

// File: rtl/pending_scoreboard.sv
// One pending bit per register; a same-cycle set beats a clear to the same index.
module pending_scoreboard #(
  parameter int NREG  = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  output logic [NREG-1:0]  pend_vec
);
  logic [NREG-1:0] pend_nxt;

  // Clear first, then set, so a freshly issued load stays outstanding.
  always_comb begin
    pend_nxt = pend_vec;
    if (clr_en) pend_nxt[clr_idx] = 1'b0;
    if (set_en) pend_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_vec <= '0;
    else       pend_vec <= pend_nxt;
  end
endmodule

// File: rtl/regfile_bypass_sb.sv
// Register file with combinational read ports, WB->ID bypass and a load scoreboard
// whose per-port busy flags feed the ID stall logic.
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = XZR,
  parameter int BYPASS_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_byp,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic [NUM_RD-1:0]        busy,
  output logic                     pend_any
);
  localparam int NREG = 2**ADDR_W;

  // ZERO_REG may equal NREG, which no index can reach: that disables the zero register.
  function automatic logic is_zr(input logic [ADDR_W-1:0] a);
    return int'(a) == ZERO_REG;
  endfunction

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   pend_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else if (wr_en && !is_zr(wr_addr)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  pending_scoreboard #(.NREG(NREG), .IDX_W(ADDR_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (pend_set && !is_zr(pend_addr)),
    .set_idx  (pend_addr),
    .clr_en   (wr_en),
    .clr_idx  (wr_addr),
    .pend_vec (pend_vec)
  );

  assign pend_any = |pend_vec;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zr;
    logic              hit;
    assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
    assign zr  = is_zr(ra);
    assign hit = (BYPASS_EN != 0) && wr_en && (wr_addr == ra);

    // A bypassed read already has its value, so it must not stall.
    assign rd_data[i*DATA_W +: DATA_W] = zr ? '0 : (hit ? wr_data : mem[ra]);
    assign rd_byp[i] = !zr && hit;
    assign busy[i]   = !zr && !hit && pend_vec[ra];
  end
endmodule
